// File: rtl/mem_req_arbiter.sv
// Two-port round-robin arbiter issuing one outstanding request to a single-port memory interface.
// A watchdog turns a hung downstream transaction into an error completion for the owning port.
module mem_req_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic                m0_rreq,
  input  logic                m0_wreq,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_done,
  output logic                m0_err,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic                m1_rreq,
  input  logic                m1_wreq,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_done,
  output logic                m1_err,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rreq,
  output logic                mem_wreq,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_done,
  output logic [1:0]          grant,
  output logic                busy
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned WDOG_W = 16;
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT);
  localparam logic [WDOG_W-1:0] WDOG_MAX   = '1;
  localparam bit WDOG_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;     // 1 = port 1 owns the transaction
  logic                rr_last_q, rr_last_d; // 1 = port 1 was granted last
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic                mem_rreq_q, mem_rreq_d;
  logic                mem_wreq_q, mem_wreq_d;
  logic [1:0]          grant_q, grant_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
  logic                m0_done_q, m0_done_d;
  logic                m1_done_q, m1_done_d;
  logic                m0_err_q, m0_err_d;
  logic                m1_err_q, m1_err_d;

  logic req0, req1, pick1, pick_wr;

  // State and output registers; reset drops any transaction in flight.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      rr_last_q   <= 1'b1;
      wdog_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      mem_rreq_q  <= 1'b0;
      mem_wreq_q  <= 1'b0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      m0_done_q   <= 1'b0;
      m1_done_q   <= 1'b0;
      m0_err_q    <= 1'b0;
      m1_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_last_q   <= rr_last_d;
      wdog_q      <= wdog_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_rreq_q  <= mem_rreq_d;
      mem_wreq_q  <= mem_wreq_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      m0_done_q   <= m0_done_d;
      m1_done_q   <= m1_done_d;
      m0_err_q    <= m0_err_d;
      m1_err_q    <= m1_err_d;
    end
  end

  // Arbitration, request issue, completion capture and watchdog.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_last_d   = rr_last_q;
    wdog_d      = wdog_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_rreq_d  = 1'b0;
    mem_wreq_d  = 1'b0;
    grant_d     = grant_q;
    busy_d      = busy_q;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    m0_done_d   = 1'b0;
    m1_done_d   = 1'b0;
    m0_err_d    = 1'b0;
    m1_err_d    = 1'b0;

    req0    = m0_rreq | m0_wreq;
    req1    = m1_rreq | m1_wreq;
    // Port 1 wins when alone, or when both request and port 0 was served last.
    pick1   = req1 & (~req0 | ~rr_last_q);
    // rreq+wreq together on one port is treated as a write.
    pick_wr = pick1 ? m1_wreq : m0_wreq;

    unique case (state_q)
      ST_IDLE: begin
        if (req0 | req1) begin
          owner_d     = pick1;
          mem_addr_d  = pick1 ? m1_addr  : m0_addr;
          mem_wdata_d = pick1 ? m1_wdata : m0_wdata;
          mem_wstrb_d = pick1 ? m1_wstrb : m0_wstrb;
          mem_wreq_d  = pick_wr;
          mem_rreq_d  = ~pick_wr;
          grant_d     = pick1 ? 2'b10 : 2'b01;
          busy_d      = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wdog_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_done) begin
          if (owner_q) begin
            m1_rdata_d = mem_rdata;
            m1_done_d  = 1'b1;
          end else begin
            m0_rdata_d = mem_rdata;
            m0_done_d  = 1'b1;
          end
          state_d = ST_RESP;
        end else if (WDOG_EN && (wdog_q == WDOG_LIMIT)) begin
          if (owner_q) begin
            m1_rdata_d = '0;
            m1_done_d  = 1'b1;
            m1_err_d   = 1'b1;
          end else begin
            m0_rdata_d = '0;
            m0_done_d  = 1'b1;
            m0_err_d   = 1'b1;
          end
          state_d = ST_RESP;
        end else if (wdog_q != WDOG_MAX) begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      ST_RESP: begin
        rr_last_d = owner_q;
        grant_d   = '0;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_addr  = mem_addr_q;
  assign mem_rreq  = mem_rreq_q;
  assign mem_wreq  = mem_wreq_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign grant     = grant_q;
  assign busy      = busy_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign m0_done   = m0_done_q;
  assign m1_done   = m1_done_q;
  assign m0_err    = m0_err_q;
  assign m1_err    = m1_err_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: transaction-level reference model checked every cycle,
// directed scenarios, and literal expectations on completion order, data and latency.
module tb_mem_req_arbiter;

  localparam int TMO = 8;

  logic        ACLK;
  logic        ARESET;
  logic [31:0] m0_addr = '0, m1_addr = '0;
  logic        m0_rreq = 1'b0, m0_wreq = 1'b0, m1_rreq = 1'b0, m1_wreq = 1'b0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_done, m1_done, m0_err, m1_err;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_rreq, mem_wreq;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;
  logic        mem_done = 1'b0;
  logic [1:0]  grant;
  logic        busy;

  mem_req_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .m0_addr(m0_addr), .m0_rreq(m0_rreq), .m0_wreq(m0_wreq), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_err(m0_err),
    .m1_addr(m1_addr), .m1_rreq(m1_rreq), .m1_wreq(m1_wreq), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
    .mem_addr(mem_addr), .mem_rreq(mem_rreq), .mem_wreq(mem_wreq), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .grant(grant), .busy(busy)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h time=%0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    bit          wr;
  } cmd_t;

  cmd_t q0[$];
  cmd_t q1[$];

  function automatic cmd_t mk(input logic [31:0] a, input bit wr, input logic [31:0] d,
                              input logic [3:0] s);
    cmd_t c;
    c.addr = a; c.wr = wr; c.wdata = d; c.wstrb = s;
    return c;
  endfunction

  // Reference model: expected outputs after each edge, derived from transaction age.
  int          m_owner;  // -1 when no transaction is open
  int          m_age;    // edges since the grant edge
  bit          m_resp;   // completion reported; release on the following edge
  bit          m_last;   // 1 = port 1 served last
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_wstrb;
  bit          e_rreq, e_wreq, e_busy;
  logic [1:0]  e_grant;
  logic [31:0] e_rdata [2];
  bit          e_done [2];
  bit          e_err [2];

  task automatic model_step();
    bit r0, r1;
    if (ARESET) begin
      m_owner = -1; m_age = 0; m_resp = 0; m_last = 1;
      e_addr = '0; e_wdata = '0; e_wstrb = '0; e_rreq = 0; e_wreq = 0;
      e_grant = '0; e_busy = 0;
      e_rdata[0] = '0; e_rdata[1] = '0;
      e_done[0] = 0; e_done[1] = 0; e_err[0] = 0; e_err[1] = 0;
      return;
    end
    r0 = m0_rreq | m0_wreq;
    r1 = m1_rreq | m1_wreq;
    e_rreq = 0; e_wreq = 0;
    e_done[0] = 0; e_done[1] = 0; e_err[0] = 0; e_err[1] = 0;
    if (m_owner < 0) begin
      if (r0 || r1) begin
        m_owner = (r0 && r1) ? (m_last ? 0 : 1) : (r0 ? 0 : 1);
        m_age = 0; m_resp = 0;
        if (m_owner == 0) begin
          e_addr = m0_addr; e_wdata = m0_wdata; e_wstrb = m0_wstrb;
          e_wreq = m0_wreq; e_rreq = !m0_wreq;
        end else begin
          e_addr = m1_addr; e_wdata = m1_wdata; e_wstrb = m1_wstrb;
          e_wreq = m1_wreq; e_rreq = !m1_wreq;
        end
        e_grant = (m_owner == 0) ? 2'b01 : 2'b10;
        e_busy = 1;
      end
    end else if (m_resp) begin
      m_last = (m_owner == 1);
      m_owner = -1; e_grant = '0; e_busy = 0;
    end else begin
      m_age++;
      // Edge at age 2+j ends the j-th wait cycle.
      if (m_age >= 2) begin
        if (mem_done) begin
          e_rdata[m_owner] = mem_rdata; e_done[m_owner] = 1; m_resp = 1;
        end else if (TMO != 0 && (m_age - 2) == TMO) begin
          e_rdata[m_owner] = '0; e_done[m_owner] = 1; e_err[m_owner] = 1; m_resp = 1;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge ACLK or posedge ARESET);
      model_step();
    end
  end

  // Observation log used by the literal expectations.
  int          cyc = 0;
  int          pulse_cnt = 0;
  int          pulse_cyc = 0;
  int          done_cyc = 0;
  int          served[$];
  logic [1:0]  grant_log[$];
  logic [31:0] pulse_wdata = '0;
  logic [3:0]  pulse_wstrb = '0;
  logic [31:0] rd0_seen = '0, rd1_seen = '0;
  logic        err0_seen = 1'b0, err1_seen = 1'b0;

  // Per-cycle comparison against the model, then logging.
  initial begin
    forever begin
      @(negedge ACLK);
      cyc++;
      check("mem_addr",  mem_addr,  e_addr);
      check("mem_wdata", mem_wdata, e_wdata);
      check("mem_wstrb", 32'(mem_wstrb), 32'(e_wstrb));
      check("mem_rreq",  32'(mem_rreq),  32'(e_rreq));
      check("mem_wreq",  32'(mem_wreq),  32'(e_wreq));
      check("grant",     32'(grant),     32'(e_grant));
      check("busy",      32'(busy),      32'(e_busy));
      check("m0_rdata",  m0_rdata, e_rdata[0]);
      check("m1_rdata",  m1_rdata, e_rdata[1]);
      check("m0_done",   32'(m0_done), 32'(e_done[0]));
      check("m1_done",   32'(m1_done), 32'(e_done[1]));
      check("m0_err",    32'(m0_err),  32'(e_err[0]));
      check("m1_err",    32'(m1_err),  32'(e_err[1]));
      if (mem_rreq || mem_wreq) begin
        pulse_cnt++; pulse_cyc = cyc;
        grant_log.push_back(grant);
        pulse_wdata = mem_wdata; pulse_wstrb = mem_wstrb;
      end
      if (m0_done) begin served.push_back(0); rd0_seen = m0_rdata; err0_seen = m0_err; done_cyc = cyc; end
      if (m1_done) begin served.push_back(1); rd1_seen = m1_rdata; err1_seen = m1_err; done_cyc = cyc; end
    end
  end

  // Downstream memory: mem_done resp_delay cycles after the request pulse; -1 never answers.
  int          resp_delay = 3;
  logic [31:0] resp_data = '0;
  initial begin
    forever begin
      @(negedge ACLK);
      if ((mem_rreq || mem_wreq) && resp_delay > 0) begin
        repeat (resp_delay) @(posedge ACLK);
        #1; mem_done = 1'b1; mem_rdata = resp_data;
        @(posedge ACLK);
        #1; mem_done = 1'b0;
      end
    end
  end

  // Port 0 requester: holds the request until done, drops on the edge that samples it.
  initial begin
    cmd_t c;
    bit   got;
    int   n;
    forever begin
      @(posedge ACLK); #1;
      while (q0.size() != 0 && !ARESET) begin
        c = q0.pop_front();
        m0_addr = c.addr; m0_wdata = c.wdata; m0_wstrb = c.wstrb;
        m0_wreq = c.wr; m0_rreq = !c.wr;
        got = 0; n = 0;
        while (!got && n < 200) begin
          @(negedge ACLK);
          if (m0_done || ARESET) got = 1;
          n++;
        end
        check("p0_done_seen", 32'(got), 32'd1);
        @(posedge ACLK); #1;
        m0_rreq = 1'b0; m0_wreq = 1'b0;
      end
    end
  end

  // Port 1 requester.
  initial begin
    cmd_t c;
    bit   got;
    int   n;
    forever begin
      @(posedge ACLK); #1;
      while (q1.size() != 0 && !ARESET) begin
        c = q1.pop_front();
        m1_addr = c.addr; m1_wdata = c.wdata; m1_wstrb = c.wstrb;
        m1_wreq = c.wr; m1_rreq = !c.wr;
        got = 0; n = 0;
        while (!got && n < 200) begin
          @(negedge ACLK);
          if (m1_done || ARESET) got = 1;
          n++;
        end
        check("p1_done_seen", 32'(got), 32'd1);
        @(posedge ACLK); #1;
        m1_rreq = 1'b0; m1_wreq = 1'b0;
      end
    end
  end

  task automatic wait_served(input int n, input string nm);
    int k = 0;
    while (served.size() < n && k < 300) begin
      @(negedge ACLK);
      k++;
    end
    repeat (3) @(negedge ACLK);
    check(nm, 32'(served.size()), 32'(n));
  endtask

  task automatic pulse_reset();
    @(posedge ACLK); #1;
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
  endtask

  initial begin
    int p0;
    int k;
    ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
    @(negedge ACLK);
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    // Single read on port 0, memory answers 3 cycles after the pulse.
    served.delete();
    resp_delay = 3; resp_data = 32'hA5A5_A5A5;
    q0.push_back(mk(32'h100, 0, 32'h0, 4'h0));
    wait_served(1, "t1_count");
    check("t1_rdata", rd0_seen, 32'hA5A5_A5A5);
    check("t1_err", 32'(err0_seen), 32'd0);
    check("t1_latency", 32'(done_cyc - pulse_cyc), 32'd4);

    // Simultaneous requests after reset: port 0 first, then port 1's write.
    pulse_reset();
    served.delete(); grant_log.delete();
    resp_delay = 2; resp_data = 32'h1111_1111;
    q0.push_back(mk(32'h200, 0, 32'h0, 4'h0));
    q1.push_back(mk(32'h300, 1, 32'hDEAD_BEEF, 4'hC));
    wait_served(2, "t2_count");
    check("t2_first", 32'(served[0]), 32'd0);
    check("t2_second", 32'(served[1]), 32'd1);
    check("t2_grant0", 32'(grant_log[0]), 32'd1);
    check("t2_grant1", 32'(grant_log[1]), 32'd2);
    check("t2_wdata", pulse_wdata, 32'hDEAD_BEEF);
    check("t2_wstrb", 32'(pulse_wstrb), 32'hC);

    // Both ports requesting continuously: strict alternation, one-cycle pulses.
    served.delete();
    p0 = pulse_cnt;
    resp_delay = 1; resp_data = 32'h0000_0042;
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mk(32'h400 + 32'(i), 0, 32'h0, 4'h0));
      q1.push_back(mk(32'h500 + 32'(i), 1, 32'h1234_0000 + 32'(i), 4'hF));
    end
    wait_served(6, "t3_count");
    for (int i = 0; i < 6; i++) check("t3_order", 32'(served[i]), 32'(i % 2));
    check("t3_pulses", 32'(pulse_cnt - p0), 32'd6);

    // Memory never answers: watchdog error, then a normal transaction.
    served.delete();
    resp_delay = -1;
    q1.push_back(mk(32'h700, 0, 32'h0, 4'h0));
    wait_served(1, "t4_count");
    check("t4_err", 32'(err1_seen), 32'd1);
    check("t4_rdata", rd1_seen, 32'd0);
    check("t4_latency", 32'(done_cyc - pulse_cyc), 32'(TMO + 2));
    resp_delay = 2; resp_data = 32'h5555_AAAA;
    q1.push_back(mk(32'h704, 0, 32'h0, 4'h0));
    wait_served(2, "t4b_count");
    check("t4b_err", 32'(err1_seen), 32'd0);
    check("t4b_rdata", rd1_seen, 32'h5555_AAAA);

    // mem_done on the very cycle the watchdog expires: data wins.
    served.delete();
    resp_delay = TMO + 1; resp_data = 32'h0F0F_0F0F;
    q0.push_back(mk(32'h800, 0, 32'h0, 4'h0));
    wait_served(1, "t5_count");
    check("t5_err", 32'(err0_seen), 32'd0);
    check("t5_rdata", rd0_seen, 32'h0F0F_0F0F);
    check("t5_latency", 32'(done_cyc - pulse_cyc), 32'(TMO + 2));

    // Reset during WAIT, late mem_done ignored, next grant goes to port 0.
    served.delete();
    resp_delay = 5; resp_data = 32'hBAD0_BAD0;
    p0 = pulse_cnt;
    q0.push_back(mk(32'h900, 1, 32'hCAFE_F00D, 4'h3));
    k = 0;
    while (pulse_cnt == p0 && k < 50) begin
      @(negedge ACLK);
      k++;
    end
    check("t6_pulse_seen", 32'(pulse_cnt - p0), 32'd1);
    repeat (1) @(posedge ACLK);
    pulse_reset();
    repeat (8) @(negedge ACLK);
    check("t6_no_done", 32'(served.size()), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_grant", 32'(grant), 32'd0);
    check("t6_m0_rdata", m0_rdata, 32'd0);
    served.delete(); grant_log.delete();
    resp_delay = 1; resp_data = 32'h7777_0001;
    q1.push_back(mk(32'hA04, 0, 32'h0, 4'h0));
    q0.push_back(mk(32'hA00, 0, 32'h0, 4'h0));
    wait_served(2, "t6b_count");
    check("t6b_first", 32'(served[0]), 32'd0);
    check("t6b_grant", 32'(grant_log[0]), 32'd1);

    repeat (2) @(negedge ACLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
